// File: rtl/pulse_stretcher.sv
// pulse_stretcher: multi-channel retriggerable one-shot.
// Turns single-cycle trigger pulses into levels held for `duration` enable ticks.
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst       synchronous reset, active-high
//   enable    timebase tick; active counts decrement only when high
//   trig      per-channel start pulse (sampled every cycle)
//   clear     per-channel abort (sampled every cycle, highest priority)
//   duration  hold length in ticks, latched per channel on load/reload
//   out       registered stretched level per channel (asserted = ~INVERT)
//   busy      registered, high while any channel is active
module pulse_stretcher #(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned COUNT_W   = 8,
    parameter int unsigned RETRIGGER = 1,
    parameter int unsigned INVERT    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [WIDTH-1:0]   trig,
    input  logic [WIDTH-1:0]   clear,
    input  logic [COUNT_W-1:0] duration,
    output logic [WIDTH-1:0]   out,
    output logic               busy
);

    localparam logic RETRIG_EN = (RETRIGGER != 0);
    localparam logic INV       = (INVERT != 0);

    // Per-channel state: bit i set means channel i is ACTIVE.
    logic [WIDTH-1:0]   active_q;
    logic [WIDTH-1:0]   active_d;
    logic [COUNT_W-1:0] cnt_q [WIDTH];
    logic [COUNT_W-1:0] cnt_d [WIDTH];

    logic [WIDTH-1:0]   out_d;
    logic               busy_d;

    // A trigger loads the counter when idle, or reloads it when retriggering is enabled.
    // A zero duration never loads, so an active channel then just keeps ticking.
    logic               dur_nz_c;
    logic [WIDTH-1:0]   load_c;

    assign dur_nz_c = (duration != '0);
    assign load_c   = trig & {WIDTH{dur_nz_c}} & (~active_q | {WIDTH{RETRIG_EN}});

    // State register plus registered outputs, all updated from next-state values.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
            out  <= {WIDTH{INV}};
            busy <= 1'b0;
        end else begin
            active_q <= active_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            out  <= out_d;
            busy <= busy_d;
        end
    end

    // Next-state logic; priority per channel is clear > trig > enable tick.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (clear[i]) begin
                active_d[i] = 1'b0;
                cnt_d[i]    = '0;
            end else if (load_c[i]) begin
                // The tick in a load/reload cycle is deliberately dropped.
                active_d[i] = 1'b1;
                cnt_d[i]    = duration;
            end else if (active_q[i] && enable) begin
                if (cnt_q[i] == COUNT_W'(1)) begin
                    active_d[i] = 1'b0;
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] - COUNT_W'(1);
                end
            end
        end
    end

    // Output decode from next state so out/busy change in the same cycle as the state.
    always_comb begin
        out_d  = active_d ^ {WIDTH{INV}};
        busy_d = |active_d;
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher: three variants (retrigger, non-retrigger,
// inverted) share one stimulus stream; expected outputs are pushed to a scoreboard
// when inputs are driven and popped after the clock edge.
module tb_pulse_stretcher;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [1:0] trig;
    logic [1:0] clear;
    logic [7:0] duration;

    logic [1:0] out_rt, out_nr, out_inv;
    logic       busy_rt, busy_nr, busy_inv;

    pulse_stretcher #(.WIDTH(2), .COUNT_W(8), .RETRIGGER(1), .INVERT(0)) u_rt (
        .clk(clk), .rst(rst), .enable(enable), .trig(trig), .clear(clear),
        .duration(duration), .out(out_rt), .busy(busy_rt));

    pulse_stretcher #(.WIDTH(2), .COUNT_W(8), .RETRIGGER(0), .INVERT(0)) u_nr (
        .clk(clk), .rst(rst), .enable(enable), .trig(trig), .clear(clear),
        .duration(duration), .out(out_nr), .busy(busy_nr));

    pulse_stretcher #(.WIDTH(2), .COUNT_W(8), .RETRIGGER(1), .INVERT(1)) u_inv (
        .clk(clk), .rst(rst), .enable(enable), .trig(trig), .clear(clear),
        .duration(duration), .out(out_inv), .busy(busy_inv));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] trig;
        logic [1:0] clr;
        logic [7:0] dur;
        logic [1:0] exp_out;
        logic       exp_busy;
    } vec_t;

    typedef struct {
        logic [1:0] o_rt;
        logic [1:0] o_nr;
        logic [1:0] o_inv;
        logic       b_rt;
        logic       b_nr;
        logic       b_inv;
        logic       has_tbl;
        logic [1:0] t_out;
        logic       t_busy;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;
    int   tk_rt    = 0;
    int   tk_nr    = 0;

    // Reference model: index 0 = retriggerable, 1 = non-retriggerable.
    bit m_act [2][2];
    int m_cnt [2][2];

    function automatic void model_step(input logic r, input logic en, input logic [1:0] tg,
                                       input logic [1:0] cl, input logic [7:0] dur);
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 2; c++) begin
                if (r) begin
                    m_act[m][c] = 1'b0;
                    m_cnt[m][c] = 0;
                end else if (cl[c]) begin
                    m_act[m][c] = 1'b0;
                    m_cnt[m][c] = 0;
                end else if (tg[c] && dur != 8'd0 && (!m_act[m][c] || m == 0)) begin
                    m_act[m][c] = 1'b1;
                    m_cnt[m][c] = int'(dur);
                end else if (m_act[m][c] && en) begin
                    m_cnt[m][c] = m_cnt[m][c] - 1;
                    if (m_cnt[m][c] == 0) m_act[m][c] = 1'b0;
                end
            end
        end
    endfunction

    function automatic vec_t mk(input logic r, input logic en, input logic [1:0] tg,
                                input logic [1:0] cl, input logic [7:0] dur,
                                input logic [1:0] eo, input logic eb);
        vec_t v;
        v.rst = r; v.en = en; v.trig = tg; v.clr = cl; v.dur = dur;
        v.exp_out = eo; v.exp_busy = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%b expected=%b", name, step_no, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs, push model expectation, compare after the edge.
    task automatic step(input logic r, input logic en, input logic [1:0] tg,
                        input logic [1:0] cl, input logic [7:0] dur,
                        input logic has_tbl = 1'b0, input logic [1:0] t_out = 2'b00,
                        input logic t_busy = 1'b0);
        exp_t e;
        rst = r; enable = en; trig = tg; clear = cl; duration = dur;
        if (en && out_rt[0] === 1'b1) tk_rt++;
        if (en && out_nr[0] === 1'b1) tk_nr++;
        model_step(r, en, tg, cl, dur);
        e.o_rt    = {m_act[0][1], m_act[0][0]};
        e.o_nr    = {m_act[1][1], m_act[1][0]};
        e.o_inv   = ~e.o_rt;
        e.b_rt    = |e.o_rt;
        e.b_nr    = |e.o_nr;
        e.b_inv   = |e.o_rt;
        e.has_tbl = has_tbl;
        e.t_out   = t_out;
        e.t_busy  = t_busy;
        sb.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        e = sb.pop_front();
        chk("out_rt",   out_rt,   e.o_rt);
        chk("busy_rt",  {1'b0, busy_rt},  {1'b0, e.b_rt});
        chk("out_nr",   out_nr,   e.o_nr);
        chk("busy_nr",  {1'b0, busy_nr},  {1'b0, e.b_nr});
        chk("out_inv",  out_inv,  e.o_inv);
        chk("busy_inv", {1'b0, busy_inv}, {1'b0, e.b_inv});
        if (e.has_tbl) begin
            chk("tbl_out",  out_rt, e.t_out);
            chk("tbl_busy", {1'b0, busy_rt}, {1'b0, e.t_busy});
        end
    endtask

    vec_t vecs [20];

    initial begin
        int n;
        rst = 1'b1; enable = 1'b0; trig = 2'b00; clear = 2'b00; duration = 8'd0;
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < 2; c++) begin
                m_act[m][c] = 1'b0;
                m_cnt[m][c] = 0;
            end

        // Hand-derived vectors: expected out/busy of the retriggerable variant after each edge.
        //              rst  en    trig   clr    dur    out    busy
        vecs[0]  = mk(1'b1, 1'b1, 2'b11, 2'b00, 8'd3, 2'b00, 1'b0); // reset wins over trig
        vecs[1]  = mk(1'b1, 1'b0, 2'b11, 2'b00, 8'd3, 2'b00, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 2'b00, 2'b00, 8'd3, 2'b00, 1'b0);
        vecs[3]  = mk(1'b0, 1'b0, 2'b01, 2'b00, 8'd3, 2'b01, 1'b1); // load, 1-cycle latency
        vecs[4]  = mk(1'b0, 1'b0, 2'b00, 2'b00, 8'd3, 2'b01, 1'b1);
        vecs[5]  = mk(1'b0, 1'b1, 2'b00, 2'b00, 8'd3, 2'b01, 1'b1); // tick 1
        vecs[6]  = mk(1'b0, 1'b0, 2'b00, 2'b00, 8'd3, 2'b01, 1'b1);
        vecs[7]  = mk(1'b0, 1'b1, 2'b00, 2'b00, 8'd3, 2'b01, 1'b1); // tick 2
        vecs[8]  = mk(1'b0, 1'b1, 2'b00, 2'b00, 8'd3, 2'b00, 1'b0); // tick 3 ends
        vecs[9]  = mk(1'b0, 1'b0, 2'b00, 2'b00, 8'd3, 2'b00, 1'b0);
        vecs[10] = mk(1'b0, 1'b1, 2'b10, 2'b00, 8'd2, 2'b10, 1'b1); // tick in load cycle dropped
        vecs[11] = mk(1'b0, 1'b1, 2'b00, 2'b00, 8'd2, 2'b10, 1'b1);
        vecs[12] = mk(1'b0, 1'b1, 2'b00, 2'b00, 8'd2, 2'b00, 1'b0);
        vecs[13] = mk(1'b0, 1'b0, 2'b11, 2'b00, 8'd0, 2'b00, 1'b0); // zero duration ignored
        vecs[14] = mk(1'b0, 1'b0, 2'b00, 2'b00, 8'd0, 2'b00, 1'b0);
        vecs[15] = mk(1'b0, 1'b0, 2'b10, 2'b10, 8'd5, 2'b00, 1'b0); // clear beats trig
        vecs[16] = mk(1'b0, 1'b0, 2'b11, 2'b00, 8'd5, 2'b11, 1'b1);
        vecs[17] = mk(1'b0, 1'b1, 2'b00, 2'b10, 8'd5, 2'b01, 1'b1); // clear ch1 only
        vecs[18] = mk(1'b0, 1'b1, 2'b00, 2'b00, 8'd5, 2'b01, 1'b1);
        vecs[19] = mk(1'b0, 1'b0, 2'b00, 2'b01, 8'd5, 2'b00, 1'b0);

        @(negedge clk);
        for (int i = 0; i < 20; i++)
            step(vecs[i].rst, vecs[i].en, vecs[i].trig, vecs[i].clr, vecs[i].dur,
                 1'b1, vecs[i].exp_out, vecs[i].exp_busy);

        // Retrigger after 2 ticks: 6 ticks total when retriggering, 4 otherwise.
        step(1'b0, 1'b0, 2'b00, 2'b11, 8'd4);
        tk_rt = 0; tk_nr = 0;
        step(1'b0, 1'b0, 2'b01, 2'b00, 8'd4);
        for (int k = 0; k < 4; k++) step(1'b0, (k % 2) == 0, 2'b00, 2'b00, 8'd4);
        step(1'b0, 1'b0, 2'b01, 2'b00, 8'd4);
        n = 0;
        while (n < 40 && (out_rt[0] === 1'b1 || out_nr[0] === 1'b1)) begin
            step(1'b0, (n % 2) == 0, 2'b00, 2'b00, 8'd4);
            n++;
        end
        chk_int("retrig_ticks_rt", tk_rt, 6);
        chk_int("retrig_ticks_nr", tk_nr, 4);

        // Maximum duration holds for 255 ticks.
        step(1'b0, 1'b0, 2'b01, 2'b00, 8'd255);
        tk_rt = 0;
        n = 0;
        while (n < 300 && out_rt[0] === 1'b1) begin
            step(1'b0, 1'b1, 2'b00, 2'b00, 8'd255);
            n++;
        end
        chk_int("max_dur_ticks", tk_rt, 255);

        // Duration changed mid-activity has no effect on the running channel.
        step(1'b0, 1'b0, 2'b01, 2'b00, 8'd5);
        tk_rt = 0;
        n = 0;
        while (n < 20 && out_rt[0] === 1'b1) begin
            step(1'b0, 1'b1, 2'b00, 2'b00, 8'd1);
            n++;
        end
        chk_int("dur_change_ticks", tk_rt, 5);

        // Reset mid-activity, then a fresh trigger behaves normally.
        step(1'b0, 1'b0, 2'b11, 2'b00, 8'd10, 1'b1, 2'b11, 1'b1);
        step(1'b0, 1'b1, 2'b00, 2'b00, 8'd10, 1'b1, 2'b11, 1'b1);
        step(1'b1, 1'b1, 2'b00, 2'b00, 8'd10, 1'b1, 2'b00, 1'b0);
        step(1'b0, 1'b0, 2'b01, 2'b00, 8'd2,  1'b1, 2'b01, 1'b1);
        step(1'b0, 1'b1, 2'b00, 2'b00, 8'd2,  1'b1, 2'b01, 1'b1);
        step(1'b0, 1'b1, 2'b00, 2'b00, 8'd2,  1'b1, 2'b00, 1'b0);

        // Trigger held high across several ticks, then released.
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 2'b01, 2'b00, 8'd2);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 2'b00, 2'b00, 8'd2);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            logic [1:0] tg, cl;
            tg[0] = ($urandom_range(0, 7) == 0);
            tg[1] = ($urandom_range(0, 7) == 0);
            cl[0] = ($urandom_range(0, 31) == 0);
            cl[1] = ($urandom_range(0, 31) == 0);
            step(($urandom_range(0, 127) == 0), ($urandom_range(0, 1) == 1), tg, cl,
                 8'($urandom_range(0, 6)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
